// File: rtl/dma_xfer_ctrl_if.sv
// Memory request port of the DMA sequencer.
// The sequencer is the master: it raises req with we/addr and holds them until
// the memory returns a single-cycle ack.
interface dma_xfer_ctrl_if #(
    parameter int ADDR_W = 8
) ();
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ack;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        input  mem_ack
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        output mem_ack
    );
endinterface

// File: rtl/dma_xfer_ctrl.sv
// Single-channel memory-to-memory DMA sequencer.
// Moves one byte per read/write pair through the external 8-bit holding
// register, whose active-low load strobe is driven from here.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | waiting for start; outputs quiet
// RD     | reading source byte at src_ptr; load strobe fires on ack
// WR     | writing held byte to dst_ptr; pointers/counters step on ack
// FIN    | one-cycle done pulse, back to IDLE
// FAIL   | one-cycle err pulse after a request timeout, back to IDLE
module dma_xfer_ctrl #(
    parameter int ADDR_W  = 8,
    parameter int LEN_W   = 8,
    parameter int TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic [ADDR_W-1:0]  src_addr_i,
    input  logic [ADDR_W-1:0]  dst_addr_i,
    input  logic [LEN_W-1:0]   length_i,
    input  logic               abort_i,
    dma_xfer_ctrl_if.master    mem,
    output logic               hold_load_n_o,
    output logic               busy_o,
    output logic               done_o,
    output logic               err_o,
    output logic [LEN_W-1:0]   xfer_count_o
);

    // Wait counter must be able to hold the value TIMEOUT itself.
    localparam int WAIT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD   = 3'd1,
        S_WR   = 3'd2,
        S_FIN  = 3'd3,
        S_FAIL = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] src_ptr_q, src_ptr_d;
    logic [ADDR_W-1:0] dst_ptr_q, dst_ptr_d;
    logic [LEN_W-1:0]  remaining_q, remaining_d;
    logic [LEN_W-1:0]  xfer_count_q, xfer_count_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [WAIT_W-1:0] wait_inc;
    logic              ack_taken;

    // State and datapath registers; synchronous reset overrides everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            src_ptr_q    <= '0;
            dst_ptr_q    <= '0;
            remaining_q  <= '0;
            xfer_count_q <= '0;
            wait_q       <= '0;
        end else begin
            state_q      <= state_d;
            src_ptr_q    <= src_ptr_d;
            dst_ptr_q    <= dst_ptr_d;
            remaining_q  <= remaining_d;
            xfer_count_q <= xfer_count_d;
            wait_q       <= wait_d;
        end
    end

    // An ack only counts when abort is not present in the same cycle.
    always_comb begin
        ack_taken = mem.mem_ack & ~abort_i;
        wait_inc  = wait_q + 1'b1;
    end

    // Next-state, pointer, counter and wait-timer update.
    always_comb begin
        state_d      = state_q;
        src_ptr_d    = src_ptr_q;
        dst_ptr_d    = dst_ptr_q;
        remaining_d  = remaining_q;
        xfer_count_d = xfer_count_q;
        wait_d       = wait_q;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    xfer_count_d = '0;
                    wait_d       = '0;
                    if (length_i != '0) begin
                        src_ptr_d   = src_addr_i;
                        dst_ptr_d   = dst_addr_i;
                        remaining_d = length_i;
                        state_d     = S_RD;
                    end else begin
                        state_d = S_FIN;
                    end
                end
            end

            S_RD: begin
                if (abort_i) begin
                    state_d = S_IDLE;
                end else if (ack_taken) begin
                    wait_d  = '0;
                    state_d = S_WR;
                end else if (wait_inc == WAIT_LIMIT) begin
                    wait_d  = '0;
                    state_d = S_FAIL;
                end else begin
                    wait_d = wait_inc;
                end
            end

            S_WR: begin
                if (abort_i) begin
                    state_d = S_IDLE;
                end else if (ack_taken) begin
                    wait_d       = '0;
                    src_ptr_d    = src_ptr_q + 1'b1;
                    dst_ptr_d    = dst_ptr_q + 1'b1;
                    remaining_d  = remaining_q - 1'b1;
                    xfer_count_d = xfer_count_q + 1'b1;
                    // Last byte when only one was outstanding before this write.
                    if (remaining_q == LEN_W'(1)) begin
                        state_d = S_FIN;
                    end else begin
                        state_d = S_RD;
                    end
                end else if (wait_inc == WAIT_LIMIT) begin
                    wait_d  = '0;
                    state_d = S_FAIL;
                end else begin
                    wait_d = wait_inc;
                end
            end

            S_FIN: begin
                state_d = S_IDLE;
            end

            S_FAIL: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Bus and status outputs are pure decodes of the state register; the load
    // strobe is the only output that also depends on same-cycle ack/abort.
    always_comb begin
        mem.mem_req   = (state_q == S_RD) || (state_q == S_WR);
        mem.mem_we    = (state_q == S_WR);
        mem.mem_addr  = '0;
        if (state_q == S_RD) begin
            mem.mem_addr = src_ptr_q;
        end else if (state_q == S_WR) begin
            mem.mem_addr = dst_ptr_q;
        end
        hold_load_n_o = ~((state_q == S_RD) && ack_taken);
        busy_o        = (state_q != S_IDLE);
        done_o        = (state_q == S_FIN);
        err_o         = (state_q == S_FAIL);
        xfer_count_o  = xfer_count_q;
    end

endmodule

// File: tb/tb_dma_xfer_ctrl.sv
// Bench for dma_xfer_ctrl: a memory responder acks requests after a
// programmable delay, and a scoreboard queue holds the bus transactions each
// transfer is expected to produce, popped as the DUT completes them.
module tb_dma_xfer_ctrl;
    logic       clk   = 1'b0;
    logic       rst   = 1'b1;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [7:0] src   = 8'h00;
    logic [7:0] dst   = 8'h00;
    logic [7:0] len   = 8'h00;
    logic       hold_n, busy, done, err;
    logic [7:0] xfer;

    dma_xfer_ctrl_if #(.ADDR_W(8)) bus ();

    dma_xfer_ctrl #(.ADDR_W(8), .LEN_W(8), .TIMEOUT(16)) dut (
        .clk           (clk),
        .rst           (rst),
        .start_i       (start),
        .src_addr_i    (src),
        .dst_addr_i    (dst),
        .length_i      (len),
        .abort_i       (abort),
        .mem           (bus.master),
        .hold_load_n_o (hold_n),
        .busy_o        (busy),
        .done_o        (done),
        .err_o         (err),
        .xfer_count_o  (xfer)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;

    logic [8:0] sb_q[$];
    logic [8:0] exp_x;

    bit ack_en   = 1'b1;
    int ack_dly  = 0;
    int abort_rd = 0;
    int wait_n   = 0;
    int rd_n     = 0;

    int done_cnt = 0, err_cnt = 0, hold_cnt = 0, req_cycles = 0;
    int done_cyc = 0, err_cyc = 0, req_run = 0, last_run = 0;
    int t_start  = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    always @(posedge clk) cyc++;

    // Memory responder: ack after ack_dly wait cycles; optionally raise abort
    // together with the ack of the abort_rd-th read.
    always @(negedge clk) begin
        abort = 1'b0;
        if (rst || !bus.mem_req) begin
            bus.mem_ack = 1'b0;
            wait_n      = 0;
        end else if (ack_en && wait_n >= ack_dly) begin
            bus.mem_ack = 1'b1;
            wait_n      = 0;
            if (!bus.mem_we) begin
                rd_n++;
                if (rd_n == abort_rd) abort = 1'b1;
            end
        end else begin
            bus.mem_ack = 1'b0;
            wait_n++;
        end
    end

    // Monitor: counts pulses and checks every request cycle against the
    // scoreboard head, popping on a completed (non-aborted) ack.
    always @(negedge clk) begin
        #1;
        if (rst) begin
            req_run = 0;
        end else begin
            if (done) begin done_cnt++; done_cyc = cyc; end
            if (err) begin err_cnt++; err_cyc = cyc; end
            if (!hold_n) hold_cnt++;
            if (bus.mem_req) begin
                req_cycles++;
                req_run++;
                if (bus.mem_ack && abort) begin
                    check_val("hold_on_abort", 32'(hold_n), 32'd1);
                end else begin
                    if (sb_q.size() > 0)
                        check_val("bus_req", 32'({bus.mem_we, bus.mem_addr}), 32'(sb_q[0]));
                    if (bus.mem_ack) begin
                        if (sb_q.size() == 0) begin
                            check_val("sb_underflow", 32'(sb_q.size()), 32'd1);
                        end else begin
                            exp_x = sb_q.pop_front();
                            check_val("hold_on_ack", 32'(hold_n), 32'(exp_x[8]));
                        end
                    end
                end
            end else begin
                if (req_run > 0) last_run = req_run;
                req_run = 0;
            end
        end
    end

    task automatic clr_stats();
        done_cnt = 0; err_cnt = 0; hold_cnt = 0; req_cycles = 0;
        last_run = 0; rd_n = 0;
    endtask

    task automatic do_start(input logic [7:0] s, input logic [7:0] d, input logic [7:0] l,
                            input int n_push);
        @(negedge clk); #2;
        start = 1'b1; src = s; dst = d; len = l; t_start = cyc;
        for (int i = 0; i < n_push; i++) begin
            sb_q.push_back({1'b0, s + 8'(i)});
            sb_q.push_back({1'b1, d + 8'(i)});
        end
        @(negedge clk); #2;
        start = 1'b0;
    endtask

    task automatic wait_flag(input string tag, input int lim, input bit for_err);
        bit hit = 1'b0;
        for (int i = 0; i < lim && !hit; i++) begin
            @(negedge clk); #2;
            hit = for_err ? (err_cnt > 0) : (done_cnt > 0);
        end
        check_val(tag, 32'(hit), 32'd1);
        repeat (2) @(negedge clk);
        #2;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit hit;
        bus.mem_ack = 1'b0;

        // Reset values
        repeat (3) @(negedge clk);
        #2;
        check_val("rst_req",  32'(bus.mem_req),  32'd0);
        check_val("rst_we",   32'(bus.mem_we),   32'd0);
        check_val("rst_addr", 32'(bus.mem_addr), 32'd0);
        check_val("rst_hold", 32'(hold_n),       32'd1);
        check_val("rst_busy", 32'(busy),         32'd0);
        check_val("rst_done", 32'(done),         32'd0);
        check_val("rst_err",  32'(err),          32'd0);
        check_val("rst_xfer", 32'(xfer),         32'd0);
        @(negedge clk); #2;
        rst = 1'b0;

        // Basic copy, zero-wait memory
        clr_stats(); ack_en = 1'b1; ack_dly = 0;
        do_start(8'h10, 8'h80, 8'd3, 3);
        wait_flag("basic_done", 30, 1'b0);
        check_val("basic_latency", 32'(done_cyc - t_start), 32'd7);
        check_val("basic_xfer",    32'(xfer),          32'd3);
        check_val("basic_hold",    32'(hold_cnt),      32'd3);
        check_val("basic_ndone",   32'(done_cnt),      32'd1);
        check_val("basic_err",     32'(err_cnt),       32'd0);
        check_val("basic_sb",      32'(sb_q.size()),   32'd0);
        check_val("basic_busy",    32'(busy),          32'd0);

        // Reset mid-transfer while writing byte 2
        clr_stats(); ack_dly = 4;
        do_start(8'h20, 8'h40, 8'd3, 3);
        hit = 1'b0;
        for (int i = 0; i < 40 && !hit; i++) begin
            @(negedge clk); #2;
            hit = bus.mem_req && bus.mem_we && (bus.mem_addr == 8'h41);
        end
        check_val("midrst_reach_wr", 32'(hit),  32'd1);
        check_val("midrst_pre_xfer", 32'(xfer), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        check_val("midrst_req",  32'(bus.mem_req),  32'd0);
        check_val("midrst_we",   32'(bus.mem_we),   32'd0);
        check_val("midrst_addr", 32'(bus.mem_addr), 32'd0);
        check_val("midrst_hold", 32'(hold_n),       32'd1);
        check_val("midrst_busy", 32'(busy),         32'd0);
        check_val("midrst_done", 32'(done),         32'd0);
        check_val("midrst_err",  32'(err),          32'd0);
        check_val("midrst_xfer", 32'(xfer),         32'd0);
        @(negedge clk); #2;
        rst = 1'b0;
        sb_q.delete();

        // Address wrap with 3 wait cycles per request
        clr_stats(); ack_dly = 3;
        do_start(8'hFE, 8'hFF, 8'd2, 2);
        wait_flag("wrap_done", 40, 1'b0);
        check_val("wrap_latency", 32'(done_cyc - t_start), 32'd17);
        check_val("wrap_xfer",    32'(xfer),         32'd2);
        check_val("wrap_hold",    32'(hold_cnt),     32'd2);
        check_val("wrap_err",     32'(err_cnt),      32'd0);
        check_val("wrap_sb",      32'(sb_q.size()),  32'd0);

        // Zero-length transfer
        clr_stats(); ack_dly = 0;
        do_start(8'h33, 8'h44, 8'd0, 0);
        wait_flag("zero_done", 10, 1'b0);
        check_val("zero_latency", 32'(done_cyc - t_start), 32'd1);
        check_val("zero_req",     32'(req_cycles),   32'd0);
        check_val("zero_xfer",    32'(xfer),         32'd0);
        check_val("zero_hold",    32'(hold_cnt),     32'd0);

        // Timeout on the first read
        clr_stats(); ack_en = 1'b0;
        do_start(8'h50, 8'h60, 8'd2, 0);
        wait_flag("tmo_err", 40, 1'b1);
        check_val("tmo_nerr",    32'(err_cnt),           32'd1);
        check_val("tmo_done",    32'(done_cnt),          32'd0);
        check_val("tmo_req_run", 32'(last_run),          32'd16);
        check_val("tmo_latency", 32'(err_cyc - t_start), 32'd17);
        check_val("tmo_xfer",    32'(xfer),              32'd0);
        check_val("tmo_hold",    32'(hold_cnt),          32'd0);
        check_val("tmo_busy",    32'(busy),              32'd0);
        ack_en = 1'b1;

        // Abort collides with ack on read of byte 2; start during busy ignored
        clr_stats(); ack_dly = 0; abort_rd = 2;
        do_start(8'h10, 8'h20, 8'd4, 1);
        @(negedge clk); #2;
        start = 1'b1; src = 8'h99; dst = 8'hA0; len = 8'd5;
        @(negedge clk); #2;
        start = 1'b0;
        hit = 1'b0;
        for (int i = 0; i < 20 && !hit; i++) begin
            @(negedge clk); #2;
            hit = !busy;
        end
        check_val("abort_idle", 32'(hit), 32'd1);
        repeat (6) @(negedge clk);
        #2;
        abort_rd = 0;
        check_val("abort_done", 32'(done_cnt),     32'd0);
        check_val("abort_err",  32'(err_cnt),      32'd0);
        check_val("abort_xfer", 32'(xfer),         32'd1);
        check_val("abort_hold", 32'(hold_cnt),     32'd1);
        check_val("abort_sb",   32'(sb_q.size()),  32'd0);
        check_val("abort_reqs", 32'(req_cycles),   32'd3);
        check_val("abort_busy", 32'(busy),         32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
